// File: rtl/proc_inst_writer.sv
// Encodes instruction requests into bytes, queues them and writes them into the 256-entry ring.
// Optional opcode checking is enabled with PROC_INST_WRITER_OPCHK_EN.
module proc_inst_writer #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_op,
    input  logic [1:0]       req_rd,
    input  logic [1:0]       req_rs1,
    input  logic [1:0]       req_rs2,
    input  logic [7:0]       proc_pc,
    output logic             ir_we,
    output logic [7:0]       ir_waddr,
    output logic [7:0]       ir_wdata,
    output logic [CNT_W-1:0] issued_count,
    output logic             busy,
    output logic             bad_op
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {StIdle, StIssue, StStall} state_e;

    state_e        state;
    logic [7:0]    fifo_mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] fifo_count;
    logic [7:0]    wr_addr;

    logic       accept;
    logic       op_ok;
    logic       push;
    logic       fifo_empty;
    logic       ring_full;
    logic       avail;
    logic       do_issue;
    logic       fifo_push;
    logic       fifo_pop;
    logic [7:0] enc;
    logic [7:0] head;

    assign enc        = {req_op, req_rd, req_rs1, req_rs2};
    assign req_ready  = fifo_count < CW'(DEPTH);
    assign accept     = req_valid && req_ready;
`ifdef PROC_INST_WRITER_OPCHK_EN
    assign op_ok      = (req_op == 2'd1);
`else
    assign op_ok      = 1'b1;
`endif
    assign push       = accept && op_ok;
    assign fifo_empty = (fifo_count == '0);
    assign ring_full  = ((wr_addr + 8'd1) == proc_pc);
    // An incoming byte bypasses the empty FIFO so a write can follow its accept directly.
    assign avail      = !fifo_empty || push;
    assign do_issue   = avail && !ring_full;
    assign head       = fifo_empty ? enc : fifo_mem[rd_ptr];
    assign fifo_push  = push && !(do_issue && fifo_empty);
    assign fifo_pop   = do_issue && !fifo_empty;
    assign busy       = !fifo_empty || (state != StIdle);

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (fifo_push) begin
                fifo_mem[wr_ptr] <= enc;
                wr_ptr           <= wr_ptr + PW'(1);
            end
            if (fifo_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (fifo_push && !fifo_pop) begin
                fifo_count <= fifo_count + CW'(1);
            end else if (!fifo_push && fifo_pop) begin
                fifo_count <= fifo_count - CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= StIdle;
            wr_addr      <= 8'd0;
            ir_we        <= 1'b0;
            ir_waddr     <= 8'd0;
            ir_wdata     <= 8'd0;
            issued_count <= '0;
        end else begin
            ir_we <= 1'b0;
            if (do_issue) begin
                state    <= StIssue;
                ir_we    <= 1'b1;
                ir_waddr <= wr_addr;
                ir_wdata <= head;
                wr_addr  <= wr_addr + 8'd1;
                if (issued_count != '1) begin
                    issued_count <= issued_count + CNT_W'(1);
                end
            end else if (avail) begin
                state <= StStall;
            end else begin
                state <= StIdle;
            end
        end
    end

`ifdef PROC_INST_WRITER_OPCHK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            bad_op <= 1'b0;
        end else begin
            bad_op <= accept && !op_ok;
        end
    end
`else
    assign bad_op = 1'b0;
`endif

endmodule

// File: tb/tb_proc_inst_writer.sv
// Directed bench for proc_inst_writer: latency, burst, ring-full stall, wrap, reset, opcode check.
module tb_proc_inst_writer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [1:0] req_op = '0, req_rd = '0, req_rs1 = '0, req_rs2 = '0;
    logic [7:0] proc_pc = 8'h10;
    logic       ir_we;
    logic [7:0] ir_waddr, ir_wdata, issued_count;
    logic       busy, bad_op;

    int n_cmp = 0;
    int n_err = 0;
    int cycle = 0;
    logic [7:0] wa_q[$];
    logic [7:0] wd_q[$];
    int         cy_q[$];

    proc_inst_writer #(.DEPTH(4), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_rd(req_rd), .req_rs1(req_rs1), .req_rs2(req_rs2),
        .proc_pc(proc_pc), .ir_we(ir_we), .ir_waddr(ir_waddr), .ir_wdata(ir_wdata),
        .issued_count(issued_count), .busy(busy), .bad_op(bad_op)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    always @(negedge clk) begin
        if (ir_we === 1'b1) begin
            wa_q.push_back(ir_waddr);
            wd_q.push_back(ir_wdata);
            cy_q.push_back(cycle);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] enc(input logic [1:0] op, rd, rs1, rs2);
        return {op, rd, rs1, rs2};
    endfunction

    task automatic do_reset();
        @(negedge clk);
        req_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        wa_q.delete();
        wd_q.delete();
        cy_q.delete();
    endtask

    // Leaves req_valid high at the negedge after the accepting edge.
    task automatic send(input logic [1:0] op, rd, rs1, rs2);
        logic ok;
        int   n;
        n = 0;
        req_op = op; req_rd = rd; req_rs1 = rs1; req_rs2 = rs2;
        req_valid = 1'b1;
        do begin
            ok = req_ready;
            @(posedge clk);
            n++;
            if (!ok) @(negedge clk);
        end while (!ok && n < 50);
        if (!ok) check("send_timeout", {31'd0, ok}, 32'd1);
        @(negedge clk);
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        // Reset state
        do_reset();
        check("rst_ready", req_ready, 1);
        check("rst_we", ir_we, 0);
        check("rst_waddr", ir_waddr, 0);
        check("rst_wdata", ir_wdata, 0);
        check("rst_count", issued_count, 0);
        check("rst_busy", busy, 0);
        check("rst_bad_op", bad_op, 0);

        // Single request, minimum latency
        proc_pc = 8'h10;
        send(2'd1, 2'd2, 2'd3, 2'd1);
        req_valid = 1'b0;
        check("lat_we", ir_we, 1);
        check("lat_waddr", ir_waddr, 8'h00);
        check("lat_wdata", ir_wdata, 8'h6D);
        check("lat_count", issued_count, 1);
        wait_cycles(1);
        check("lat_busy_after", busy, 0);
        check("lat_we_after", ir_we, 0);

        // Burst: fill FIFO while ring is full, then release
        do_reset();
        proc_pc = 8'h01;
        for (int i = 0; i < 4; i++) send(2'd1, 2'(i), 2'(i + 1), 2'(i + 2));
        req_valid = 1'b0;
        check("burst_ready_full", req_ready, 0);
        check("burst_busy", busy, 1);
        check("burst_no_write", wa_q.size(), 0);
        proc_pc = 8'h80;
        for (int i = 4; i < 6; i++) send(2'd1, 2'(i), 2'(i + 1), 2'(i + 2));
        req_valid = 1'b0;
        wait_cycles(6);
        check("burst_nwrites", wa_q.size(), 6);
        if (wa_q.size() == 6) begin
            for (int i = 0; i < 6; i++) begin
                check("burst_addr", wa_q[i], i);
                check("burst_data", wd_q[i], enc(2'd1, 2'(i), 2'(i + 1), 2'(i + 2)));
                check("burst_consec", cy_q[i] - cy_q[0], i);
            end
        end
        check("burst_count", issued_count, 6);
        check("burst_idle", busy, 0);

        // Ring full: stall after two writes
        do_reset();
        proc_pc = 8'd3;
        for (int i = 0; i < 3; i++) send(2'd1, 2'd0, 2'd0, 2'(i));
        req_valid = 1'b0;
        wait_cycles(5);
        check("stall_nwrites", wa_q.size(), 2);
        check("stall_a0", wa_q.size() > 0 ? wa_q[0] : 8'hxx, 0);
        check("stall_a1", wa_q.size() > 1 ? wa_q[1] : 8'hxx, 1);
        check("stall_we", ir_we, 0);
        check("stall_busy", busy, 1);
        proc_pc = 8'd4;
        wait_cycles(4);
        check("unstall_nwrites", wa_q.size(), 3);
        check("unstall_a2", wa_q.size() > 2 ? wa_q[2] : 8'hxx, 2);
        check("unstall_d2", wa_q.size() > 2 ? wd_q[2] : 8'hxx, enc(2'd1, 2'd0, 2'd0, 2'd2));
        // wr_addr is now 3 and proc_pc=4: queue three more, all held
        for (int i = 0; i < 3; i++) send(2'd1, 2'd1, 2'd1, 2'(i));
        req_valid = 1'b0;
        wait_cycles(2);
        check("held_nwrites", wa_q.size(), 3);
        check("held_ready", req_ready, 1);

        // Reset mid-operation discards queued bytes
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_count", issued_count, 0);
        check("mid_rst_ready", req_ready, 1);
        check("mid_rst_we", ir_we, 0);
        wait_cycles(3);
        check("mid_rst_nwrites", wa_q.size(), 3);
        proc_pc = 8'h80;
        send(2'd1, 2'd3, 2'd3, 2'd3);
        req_valid = 1'b0;
        check("mid_rst_waddr0", ir_waddr, 8'h00);
        check("mid_rst_we1", ir_we, 1);

        // Wrap 255 -> 0 and counter saturation
        do_reset();
        for (int k = 0; k < 258; k++) begin
            proc_pc = 8'(k + 16);
            send(2'd1, 2'(k), 2'(k >> 2), 2'(k >> 4));
        end
        req_valid = 1'b0;
        wait_cycles(2);
        check("wrap_nwrites", wa_q.size(), 258);
        if (wa_q.size() == 258) begin
            check("wrap_fe", wa_q[254], 8'hFE);
            check("wrap_ff", wa_q[255], 8'hFF);
            check("wrap_00", wa_q[256], 8'h00);
            check("wrap_d00", wd_q[256], enc(2'd1, 2'(256), 2'(256 >> 2), 2'(256 >> 4)));
        end
        check("count_sat", issued_count, 8'hFF);

        // Opcode other than Add
        do_reset();
        proc_pc = 8'h80;
        send(2'd2, 2'd0, 2'd0, 2'd0);
        req_valid = 1'b0;
`ifdef PROC_INST_WRITER_OPCHK_EN
        check("opchk_bad_op", bad_op, 1);
        check("opchk_no_we", ir_we, 0);
        wait_cycles(1);
        check("opchk_pulse_end", bad_op, 0);
        check("opchk_count", issued_count, 0);
        check("opchk_nwrites", wa_q.size(), 0);
`else
        check("op2_we", ir_we, 1);
        check("op2_field", ir_wdata[7:6], 2'd2);
        check("op2_bad_op", bad_op, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
